// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf - inter-stage pipeline register for the fetch/decode front end.
//
// Holds one payload bundle (PC, prediction bits, metadata) between two adjacent
// front-end stages, using a valid/ready handshake. Each entry carries an exception
// bit. When that bit is set, the downstream cache request (out_req) is suppressed.
//
// Build option PIPE_SKID_EN:
//   defined   : main + skid entry. in_ready is a flop (~skid_valid), so there is no
//               combinational path from out_ready. occupancy spans 0..2.
//   undefined : single entry. in_ready = ~out_valid | out_ready (combinational).
//               occupancy spans 0..1.
//
// Parameters:
//   DW           payload width
//   CLR_ON_FLUSH 1: flush also zeroes held payload/excp; 0: flush only invalidates
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 drop all held entries and any same-cycle input
//   in_valid/in_ready     upstream handshake; in_excp, in_data travel with it
//   out_valid/out_ready   downstream handshake for the head entry
//   out_excp, out_data    head entry contents
//   out_req               out_valid & ~out_excp
//   out_flushed           last state-changing event was a flush (not an accept)
//   occupancy             number of held entries
module pipe_stage_buf #(
  parameter int DW           = 64,
  parameter bit CLR_ON_FLUSH = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_excp,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_excp,
  output logic          out_req,
  output logic [DW-1:0] out_data,
  output logic          out_flushed,
  output logic [1:0]    occupancy
);

  logic          main_valid_q, main_valid_d;
  logic          main_excp_q,  main_excp_d;
  logic [DW-1:0] main_data_q,  main_data_d;
  logic          flushed_q,    flushed_d;
  logic          in_fire, out_fire;

  assign out_fire = main_valid_q & out_ready;
  assign in_fire  = in_valid & in_ready & ~flush;

`ifdef PIPE_SKID_EN
  logic          skid_valid_q, skid_valid_d;
  logic          skid_excp_q,  skid_excp_d;
  logic [DW-1:0] skid_data_q,  skid_data_d;
  logic          in_ready_q,   in_ready_d;

  always_comb begin
    main_valid_d = main_valid_q;
    main_excp_d  = main_excp_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_excp_d  = skid_excp_q;
    skid_data_d  = skid_data_q;
    flushed_d    = flushed_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      flushed_d    = 1'b1;
      if (CLR_ON_FLUSH) begin
        main_excp_d = 1'b0;
        main_data_d = '0;
        skid_excp_d = 1'b0;
        skid_data_d = '0;
      end
    end else begin
      if (skid_valid_q) begin
        // in_ready is low here, so no new entry can arrive alongside the drain
        if (out_fire) begin
          main_excp_d  = skid_excp_q;
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end
      end else if (main_valid_q) begin
        if (out_fire) begin
          if (in_fire) begin
            main_excp_d = in_excp;
            main_data_d = in_data;
          end else begin
            main_valid_d = 1'b0;
          end
        end else if (in_fire) begin
          skid_valid_d = 1'b1;
          skid_excp_d  = in_excp;
          skid_data_d  = in_data;
        end
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_excp_d  = in_excp;
        main_data_d  = in_data;
      end
      if (in_fire) flushed_d = 1'b0;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_excp_q  <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_excp_q  <= skid_excp_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
`else
  always_comb begin
    main_valid_d = main_valid_q;
    main_excp_d  = main_excp_q;
    main_data_d  = main_data_q;
    flushed_d    = flushed_q;
    if (flush) begin
      main_valid_d = 1'b0;
      flushed_d    = 1'b1;
      if (CLR_ON_FLUSH) begin
        main_excp_d = 1'b0;
        main_data_d = '0;
      end
    end else if (in_fire) begin
      main_valid_d = 1'b1;
      main_excp_d  = in_excp;
      main_data_d  = in_data;
      flushed_d    = 1'b0;
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end
  end

  assign in_ready  = ~main_valid_q | out_ready;
  assign occupancy = {1'b0, main_valid_q};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_excp_q  <= 1'b0;
      main_data_q  <= '0;
      flushed_q    <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_excp_q  <= main_excp_d;
      main_data_q  <= main_data_d;
      flushed_q    <= flushed_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_excp    = main_excp_q;
  assign out_data    = main_data_q;
  assign out_req     = main_valid_q & ~main_excp_q;
  assign out_flushed = flushed_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_excp;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_excp;
  logic        out_req;
  logic [63:0] out_data;
  logic        out_flushed;
  logic [1:0]  occupancy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DW(64), .CLR_ON_FLUSH(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_excp(in_excp), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_excp(out_excp),
    .out_req(out_req), .out_data(out_data), .out_flushed(out_flushed),
    .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle so registered outputs are stable
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_excp = 1'b0;
    in_data = 64'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_out_valid",   64'(out_valid),   64'h0);
    chk("rst_in_ready",    64'(in_ready),    64'h1);
    chk("rst_out_flushed", 64'(out_flushed), 64'h1);
    chk("rst_occupancy",   64'(occupancy),   64'h0);
    chk("rst_out_data",    out_data,         64'h0);
    chk("rst_out_req",     64'(out_req),     64'h0);
    chk("rst_out_excp",    64'(out_excp),    64'h0);

    // first entry, one-cycle latency
    in_valid = 1'b1; in_data = 64'h1C00_0000;
    tick();
    in_valid = 1'b0;
    chk("first_valid",   64'(out_valid),   64'h1);
    chk("first_data",    out_data,         64'h1C00_0000);
    chk("first_req",     64'(out_req),     64'h1);
    chk("first_flushed", 64'(out_flushed), 64'h0);
    chk("first_occ",     64'(occupancy),   64'h1);
    out_ready = 1'b1;
    tick();
    chk("drain_valid", 64'(out_valid), 64'h0);
    chk("drain_occ",   64'(occupancy), 64'h0);

    // back-to-back stream with out_ready high
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 64'h10 + 64'(4 * i);
      #1 chk("stream_in_ready", 64'(in_ready), 64'h1);
      tick();
      chk("stream_data",  out_data,          64'h10 + 64'(4 * i));
      chk("stream_valid", 64'(out_valid),    64'h1);
      chk("stream_occ",   64'(occupancy),    64'h1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", 64'(out_valid), 64'h0);

`ifdef PIPE_SKID_EN
    // stall fills main then skid
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hA0;
    tick();
    in_data = 64'hA4;
    tick();
    in_valid = 1'b0;
    chk("skid_occ",      64'(occupancy), 64'h2);
    chk("skid_in_ready", 64'(in_ready),  64'h0);
    chk("skid_head",     out_data,       64'hA0);
    out_ready = 1'b1;
    #1 chk("skid_in_ready_reg", 64'(in_ready), 64'h0);
    tick();
    chk("skid_second",   out_data,       64'hA4);
    chk("skid_occ1",     64'(occupancy), 64'h1);
    chk("skid_ready_ret", 64'(in_ready), 64'h1);
    tick();
    chk("skid_empty",    64'(out_valid), 64'h0);
`else
    // single entry: in_ready follows out_ready combinationally while full
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hB0;
    tick();
    in_valid = 1'b0;
    chk("single_in_ready_stall", 64'(in_ready), 64'h0);
    out_ready = 1'b1;
    #1 chk("single_in_ready_comb", 64'(in_ready), 64'h1);
    in_valid = 1'b1; in_data = 64'hB4;
    tick();
    in_valid = 1'b0;
    chk("single_replace_data",  out_data,       64'hB4);
    chk("single_replace_occ",   64'(occupancy), 64'h1);
    tick();
    chk("single_empty", 64'(out_valid), 64'h0);
`endif

    // exception entry suppresses request
    out_ready = 1'b0;
    in_valid = 1'b1; in_excp = 1'b1; in_data = 64'h3;
    tick();
    in_valid = 1'b0; in_excp = 1'b0;
    chk("excp_valid", 64'(out_valid), 64'h1);
    chk("excp_bit",   64'(out_excp),  64'h1);
    chk("excp_req",   64'(out_req),   64'h0);
    chk("excp_data",  out_data,       64'h3);

`ifdef PIPE_SKID_EN
    in_valid = 1'b1; in_data = 64'h55;
    tick();
    chk("pre_flush_occ", 64'(occupancy), 64'h2);
`endif

    // flush with a same-cycle input offered
    in_valid = 1'b1; in_data = 64'h77; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid",    64'(out_valid),   64'h0);
    chk("flush_occ",      64'(occupancy),   64'h0);
    chk("flush_flushed",  64'(out_flushed), 64'h1);
    chk("flush_data",     out_data,         64'h0);
    chk("flush_excp",     64'(out_excp),    64'h0);
    chk("flush_in_ready", 64'(in_ready),    64'h1);
    tick();
    chk("flush_dropped",  64'(out_valid),   64'h0);

    // accept after flush clears out_flushed
    in_valid = 1'b1; in_data = 64'h99;
    tick();
    in_valid = 1'b0;
    chk("post_flush_data",    out_data,         64'h99);
    chk("post_flush_flushed", 64'(out_flushed), 64'h0);

    // flush together with out_fire: head delivered, nothing survives
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_fire_valid", 64'(out_valid), 64'h0);

    // reset mid-operation
    in_valid = 1'b1; in_data = 64'hCC;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid",   64'(out_valid),   64'h0);
    chk("mid_rst_flushed", 64'(out_flushed), 64'h1);
    chk("mid_rst_data",    out_data,         64'h0);
    chk("mid_rst_occ",     64'(occupancy),   64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised inter-stage pipeline register for the fetch/decode pipeline. It is the generalised successor of the fixed IF1→IF2 latch:
- an arbitrary-width payload bundle (PC, prediction bits, metadata) instead of a fixed field set;
- a valid/ready handshake instead of a bare write enable;
- an exception side bit that suppresses the downstream cache request;
- an optional skid entry, so `in_ready` is registered and stalls do not form a long combinational path.

It sits between any two adjacent front-end stages (IF1/IF2, IF2/ID).

## Interface
Parameters:
- DW, 64, payload width in bits (≥1).
- CLR_ON_FLUSH, 1, when 1 a flush zeroes held payload and `out_excp`; when 0 it only invalidates entries.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  kill all held entries this cycle.
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  block can accept an entry.
- in_excp  in  1  entry carries a fetch exception (e.g. ADEF).
- in_data  in  DW  payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes head.
- out_excp  out  1  head exception bit.
- out_req  out  1  `out_valid & ~out_excp`; enables the downstream cache/memory request.
- out_data  out  DW  head payload.
- out_flushed  out  1  the most recent state-changing event was a flush, not an accepted entry.
- occupancy  out  2  held entries (0..2).

## Operation
- in_fire = in_valid & in_ready & ~flush; out_fire = out_valid & out_ready.
- Storage is a main entry (drives the out_* ports) and, with PIPE_SKID_EN, a skid entry.
- Priority, highest first: reset, flush, normal update.
- flush: both entries are invalidated, any same-cycle input is dropped, and out_flushed is set to 1. With CLR_ON_FLUSH=1, payload and excp are also zeroed.
- Skid build, normal update by case:
  - main empty & in_fire → input loads main.
  - main valid & out_fire & skid empty & in_fire → input loads main.
  - main valid & ~out_fire & in_fire → input loads skid.
  - skid valid & out_fire → skid moves to main and skid empties. in_fire cannot occur in this case, because in_ready=0.
  - main valid & out_fire & no refill → main empties.
- in_ready = ~skid_valid, taken from a flop with no combinational path from out_ready.
- out_flushed is cleared on any in_fire and set on flush; it is otherwise held.
- occupancy = main_valid + skid_valid.
- Entries leave in strict FIFO order. Payload bits are never altered in transit.

## Timing
- Reset values: out_valid 0, out_excp 0, out_data 0, out_req 0, skid empty, in_ready 1, out_flushed 1, occupancy 0.
- Latency: an entry accepted in cycle N appears on out_* in cycle N+1.
- Throughput is 1 entry/cycle while out_ready stays high.
- After a stall releases, the skid drains in 1 cycle, and in_ready returns to 1 in the following cycle.
- flush in cycle N: out_valid=0 and in_ready=1 in cycle N+1, regardless of out_ready.
- flush together with out_fire: the consumed head counts as delivered, and nothing else survives.
- rst_n low mid-operation discards all entries at the next edge.

## Configuration
- PIPE_SKID_EN defined: 2-entry skid, registered in_ready, occupancy range 0..2.
- PIPE_SKID_EN undefined:
  - single entry; in_ready = ~out_valid | out_ready, combinational from out_ready;
  - occupancy range 0..1, with bit 1 tied to 0;
  - flush, excp and out_flushed behaviour unchanged.

## Test plan
- Reset held 2 cycles, then released → out_valid=0, in_ready=1, out_flushed=1, occupancy=0. Send in_data=0x1C000000, in_valid=1 → next cycle out_data=0x1C000000, out_req=1, out_flushed=0.
- Stream 0x10,0x14,0x18 with out_ready=1 → all three appear on consecutive cycles, one cycle after acceptance, and occupancy stays 1.
- Skid: hold out_ready=0 while sending 0xA0 then 0xA4 → occupancy=2 and in_ready=0. Raise out_ready → 0xA0 then 0xA4 delivered in order, and in_ready=1 again one cycle after the skid drains.
- in_excp=1 with in_data=0x3 → out_valid=1, out_excp=1, out_req=0.
- With occupancy=2 and in_valid=1, pulse flush → next cycle out_valid=0, occupancy=0, out_flushed=1, out_data=0 (CLR_ON_FLUSH=1), and the same-cycle input is not delivered.
- Without PIPE_SKID_EN: out_valid=1, out_ready=0 → in_ready=0. Toggle out_ready=1 in the same cycle → in_ready=1 combinationally.
